// File: rtl/booth_arb_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
// The iterative multiplier needs MUL_STEPS accumulate cycles before it raises done.
package booth_arb_pkg;
  localparam int OP_W            = 32;
  localparam int RES_W           = 64;
  localparam int MUL_STEPS       = 16;
  localparam int DEFAULT_TIMEOUT = 24;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_WAIT = 3'd2,
    ST_RUN  = 3'd3,
    ST_RESP = 3'd4
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// after ptr, wrapping around. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [N-1:0] lo_mask;
  logic [N-1:0] upper;
  logic [N-1:0] pick;

  // Prefer requesters at or above ptr; otherwise wrap to the lowest index.
  always_comb begin
    lo_mask = (N'(1) << ptr) - N'(1);
    upper   = req & ~lo_mask;
    pick    = (|upper) ? upper : req;
    gnt     = pick & (~pick + N'(1));
  end
endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one iterative radix-4 Booth multiplier among NUM_REQ requesters:
// round-robin accept, CLR/WAIT/RUN sequencing, timeout, and a per-owner response.
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [RES_W-1:0]        rsp_result,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  output logic                    mul_enable,
  output logic                    mul_reset,
  input  logic                    mul_done,
  input  logic [RES_W-1:0]        mul_result,
  output state_t                  dbg_state
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic               arb_en;
  logic [IDW-1:0]     sel_id;
  logic [OP_W-1:0]    sel_a, sel_b;

  rr_arbiter #(.N(NUM_REQ), .PW(IDW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (grant)
  );

  // Handshakes: a transfer occurs in any cycle where valid and ready are both
  // high. req_ready is the one-hot round-robin winner, offered only in IDLE;
  // rsp_valid is one-hot on the owner and only that owner's rsp_ready counts.
  assign arb_en     = (state_q == ST_IDLE) && reset;
  assign req_ready  = arb_en ? grant : '0;
  assign rsp_valid  = (state_q == ST_RESP) ? (NUM_REQ'(1) << id_q) : '0;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != ST_IDLE);
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign mul_reset  = (state_q == ST_CLR);
  // Dropping enable in the done cycle stops the multiplier from taking a 17th step.
  assign mul_enable = (state_q == ST_CLR) || (state_q == ST_WAIT) ||
                      ((state_q == ST_RUN) && !mul_done);
  assign dbg_state  = state_q;

  always_comb begin
    sel_id = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_id = IDW'(i);
        sel_a  = req_a[i*OP_W +: OP_W];
        sel_b  = req_b[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && (|grant)) begin
          id_d     = sel_id;
          a_d      = sel_a;
          b_d      = sel_b;
          rr_ptr_d = (sel_id == IDW'(NUM_REQ - 1)) ? '0 : sel_id + IDW'(1);
          state_d  = ST_CLR;
        end
      end
      ST_CLR:  state_d = ST_WAIT;
      ST_WAIT: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mul_done) begin
          result_d = mul_result;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (|(rsp_valid & rsp_ready)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: a stub multiplier that raises done after the
// settle cycle plus 16 accumulations, and a round-robin / product reference model.
module tb_booth_mult_arbiter;
  import booth_arb_pkg::*;

  localparam int NR = 4;
  localparam int TO = 24;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*32-1:0] req_a = '0;
  logic [NR*32-1:0] req_b = '0;
  logic [NR-1:0]   rsp_valid;
  logic [NR-1:0]   rsp_ready = '0;
  logic [63:0]     rsp_result;
  logic            rsp_err;
  logic            busy;
  logic [31:0]     mul_a, mul_b;
  logic            mul_enable, mul_reset;
  logic            mul_done;
  logic [63:0]     mul_result;
  state_t          dbg_state;

  logic [31:0] op_a [NR];
  logic [31:0] op_b [NR];
  logic [63:0] exp_q [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          mptr = 0;
  int          cyc_cnt = 0;
  int          mstep = 0;
  logic        done_en = 1'b1;

  booth_mult_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_enable(mul_enable), .mul_reset(mul_reset),
    .mul_done(mul_done), .mul_result(mul_result), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / stub multiplier ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    return 64'(sa * sb);
  endfunction

  function automatic int rr_winner(input logic [NR-1:0] mask, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return 0;
  endfunction

  function automatic logic [NR-1:0] onehot(input int w);
    logic [NR-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // Step 0 is the settle cycle after restart, 1..16 accumulate, 17 is the done pulse.
  always @(posedge clk) begin
    if (mul_reset) mstep <= 0;
    else if (mstep == 17) mstep <= 18;
    else if (mul_enable && mstep < 17) mstep <= mstep + 1;
  end
  assign mul_done   = done_en && (mstep == 17);
  assign mul_result = mul_done ? ref_mul(mul_a, mul_b) : 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic pack_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i*32 +: 32] = op_a[i];
      req_b[i*32 +: 32] = op_b[i];
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; rsp_ready = '0; done_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mptr = 0;
    exp_q.delete();
  endtask

  // Called at a negedge with requests set; returns at the first negedge showing rsp_valid.
  task automatic run_one(output logic [NR-1:0] gnt, output int acc_cyc, output int lat,
                         output logic [63:0] res, output logic err, output logic [NR-1:0] vld);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 50) begin @(negedge clk); #1; n++; end
    gnt = req_ready;
    acc_cyc = cyc_cnt;
    @(negedge clk);
    req_valid = req_valid & ~gnt;
    lat = 1;
    while (rsp_valid == '0 && lat < 60) begin @(negedge clk); lat++; end
    res = rsp_result; err = rsp_err; vld = rsp_valid;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (rsp_valid !== '0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: valid %b err %b want 0", rsp_valid, rsp_err); end
    n_cmp++; if (rsp_result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", rsp_result); end
    n_cmp++; if ({busy, mul_enable, mul_reset, mul_a, mul_b} !== '0) begin n_fail++; $display("FAIL reset_mul: busy %b en %b rst %b a %h b %h want 0", busy, mul_enable, mul_reset, mul_a, mul_b); end
  endtask

  task automatic test_single();
    op_a[0] = 32'd3; op_b[0] = 32'hFFFF_FFFB;
    pack_ops();
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid = '0;
        n_cmp++; if ({mul_enable, mul_reset} !== 2'b11 || dbg_state !== ST_CLR) begin n_fail++; $display("FAIL single_clr: en/rst %b state %0d want 11/CLR", {mul_enable, mul_reset}, dbg_state); end
      end
      if (n == 2) begin
        n_cmp++; if ({mul_enable, mul_reset} !== 2'b10) begin n_fail++; $display("FAIL single_wait: en/rst %b want 10", {mul_enable, mul_reset}); end
        n_cmp++; if (mul_a !== 32'd3 || mul_b !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL single_ops: a %h b %h want 3 fffffffb", mul_a, mul_b); end
      end
      if (n == 18) begin
        n_cmp++; if (mul_enable !== 1'b1) begin n_fail++; $display("FAIL single_run_en: got %b want 1", mul_enable); end
      end
      if (n == 19) begin
        n_cmp++; if (mul_enable !== 1'b0 || rsp_valid !== '0) begin n_fail++; $display("FAIL single_done_cycle: en %b rsp_valid %b want 0 0", mul_enable, rsp_valid); end
      end
    end
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
    n_cmp++; if (rsp_result !== 64'hFFFF_FFFF_FFFF_FFF1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_result: got %h err %b want fffffffffffffff1 0", rsp_result, rsp_err); end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== '0) begin n_fail++; $display("FAIL single_idle: busy %b rsp_valid %b want 0 0", busy, rsp_valid); end
  endtask

  task automatic test_all_four();
    logic [NR-1:0] gnt, vld; int acc, prev_acc, lat, w; logic [63:0] res; logic err;
    do_reset();
    for (int i = 0; i < NR; i++) begin op_a[i] = $urandom; op_b[i] = $urandom ^ 32'(i); end
    pack_ops();
    req_valid = 4'hF; rsp_ready = 4'hF; prev_acc = 0;
    for (int t = 0; t < NR; t++) begin
      w = rr_winner(req_valid, mptr);
      exp_q.push_back(ref_mul(op_a[w], op_b[w]));
      run_one(gnt, acc, lat, res, err, vld);
      mptr = (w + 1) % NR;
      n_cmp++; if (gnt !== onehot(t) || gnt !== onehot(w)) begin n_fail++; $display("FAIL all4_grant: got %b want %b", gnt, onehot(t)); end
      n_cmp++; if (lat !== 20 || vld !== onehot(w)) begin n_fail++; $display("FAIL all4_latency: lat %0d vld %b want 20 %b", lat, vld, onehot(w)); end
      n_cmp++; if (res !== exp_q.pop_front() || err !== 1'b0) begin n_fail++; $display("FAIL all4_result: got %h err %b for id %0d", res, err, w); end
      if (t > 0) begin
        n_cmp++; if (acc - prev_acc !== 21) begin n_fail++; $display("FAIL all4_spacing: got %0d want 21", acc - prev_acc); end
      end
      prev_acc = acc;
    end
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_hold();
    logic [NR-1:0] gnt, vld; int acc, lat, w; logic [63:0] res, held; logic err;
    op_a[2] = $urandom; op_b[2] = $urandom; op_a[0] = $urandom; op_b[0] = $urandom;
    op_a[3] = $urandom; op_b[3] = $urandom;
    pack_ops();
    req_valid = 4'b0100;
    w = rr_winner(req_valid, mptr);
    held = ref_mul(op_a[2], op_b[2]);
    run_one(gnt, acc, lat, res, err, vld);
    mptr = (w + 1) % NR;
    n_cmp++; if (gnt !== 4'b0100 || res !== held) begin n_fail++; $display("FAIL hold_first: gnt %b res %h want 0100 %h", gnt, res, held); end
    req_valid = 4'b1001; rsp_ready = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid !== 4'b0100 || rsp_result !== held || req_ready !== '0) begin n_fail++; $display("FAIL hold_stable: vld %b res %h ready %b want 0100 %h 0000", rsp_valid, rsp_result, req_ready, held); end
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = 4'hF;
    for (int t = 0; t < 2; t++) begin
      w = rr_winner(req_valid, mptr);
      exp_q.push_back(ref_mul(op_a[w], op_b[w]));
      run_one(gnt, acc, lat, res, err, vld);
      mptr = (w + 1) % NR;
      n_cmp++; if (gnt !== onehot(w) || gnt !== (t == 0 ? 4'b1000 : 4'b0001)) begin n_fail++; $display("FAIL hold_next_grant: got %b want %b", gnt, onehot(w)); end
      n_cmp++; if (res !== exp_q.pop_front() || err !== 1'b0 || lat !== 20) begin n_fail++; $display("FAIL hold_next_result: res %h err %b lat %0d", res, err, lat); end
    end
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_timeout();
    logic [NR-1:0] gnt, vld; int acc, lat, w; logic [63:0] res; logic err;
    w = $urandom_range(0, NR - 1);
    op_a[w] = $urandom; op_b[w] = $urandom;
    pack_ops();
    done_en = 1'b0;
    req_valid = onehot(w);
    run_one(gnt, acc, lat, res, err, vld);
    mptr = (w + 1) % NR;
    n_cmp++; if (lat !== 2 + TO + 1 || vld !== onehot(w)) begin n_fail++; $display("FAIL timeout_latency: lat %0d vld %b want %0d %b", lat, vld, 2 + TO + 1, onehot(w)); end
    n_cmp++; if (err !== 1'b1 || res !== 64'h0) begin n_fail++; $display("FAIL timeout_err: err %b res %h want 1 0", err, res); end
    rsp_ready = onehot(w);
    @(negedge clk);
    rsp_ready = '0; done_en = 1'b1;
  endtask

  task automatic test_corner();
    logic [NR-1:0] gnt, vld; int acc, lat; logic [63:0] res; logic err;
    op_a[1] = 32'h8000_0000; op_b[1] = 32'h8000_0000;
    op_a[2] = 32'h7FFF_FFFF; op_b[2] = 32'hFFFF_FFFF;
    pack_ops();
    rsp_ready = 4'hF;
    req_valid = 4'b0010;
    run_one(gnt, acc, lat, res, err, vld);
    n_cmp++; if (res !== 64'h4000_0000_0000_0000 || err !== 1'b0) begin n_fail++; $display("FAIL corner_min_sq: got %h err %b want 4000000000000000 0", res, err); end
    @(negedge clk);
    req_valid = 4'b0100;
    run_one(gnt, acc, lat, res, err, vld);
    n_cmp++; if (res !== 64'hFFFF_FFFF_8000_0001 || err !== 1'b0) begin n_fail++; $display("FAIL corner_max_neg1: got %h err %b want ffffffff80000001 0", res, err); end
    mptr = 3;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] gnt, vld; int acc, lat, w; logic [63:0] res; logic err;
    w = $urandom_range(0, NR - 1);
    op_a[w] = $urandom; op_b[w] = $urandom;
    pack_ops();
    req_valid = onehot(w);
    #1;
    n_cmp++; if (req_ready !== onehot(rr_winner(req_valid, mptr))) begin n_fail++; $display("FAIL rstmid_grant: got %b want %b", req_ready, onehot(w)); end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = '0;
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({req_ready, rsp_valid, rsp_result, rsp_err, busy, mul_a, mul_b, mul_enable, mul_reset} !== '0) begin n_fail++; $display("FAIL rstmid_outputs: busy %b en %b a %h res %h not all zero", busy, mul_enable, mul_a, rsp_result); end
    reset = 1'b1; mptr = 0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_dropped: vld %b busy %b want 0 0", rsp_valid, busy); end
    end
    op_a[1] = 32'd7; op_b[1] = 32'd6;
    pack_ops();
    req_valid = 4'b0010; rsp_ready = 4'b0010;
    run_one(gnt, acc, lat, res, err, vld);
    mptr = 2;
    n_cmp++; if (gnt !== 4'b0010 || res !== 64'd42 || err !== 1'b0 || lat !== 20) begin n_fail++; $display("FAIL rstmid_after: gnt %b res %h err %b lat %0d want 0010 42 0 20", gnt, res, err, lat); end
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_random();
    logic [NR-1:0] gnt, vld, oh; int acc, lat, w, dly; logic [63:0] res, held; logic err;
    do_reset();
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          op_a[i] = $urandom; op_b[i] = $urandom; req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      if (req_valid == '0) begin
        w = $urandom_range(0, NR - 1);
        op_a[w] = $urandom; op_b[w] = $urandom; req_valid[w] = 1'b1;
      end
      pack_ops();
      w = rr_winner(req_valid, mptr);
      oh = onehot(w);
      exp_q.push_back(ref_mul(op_a[w], op_b[w]));
      rsp_ready = 4'($urandom_range(0, 15)) & ~oh;
      run_one(gnt, acc, lat, res, err, vld);
      mptr = (w + 1) % NR;
      held = exp_q.pop_front();
      n_cmp++; if (gnt !== oh) begin n_fail++; $display("FAIL rand_grant: txn %0d got %b want %b", t, gnt, oh); end
      n_cmp++; if (res !== held || err !== 1'b0 || lat !== 20 || vld !== oh) begin n_fail++; $display("FAIL rand_result: txn %0d res %h err %b lat %0d vld %b want %h 0 20 %b", t, res, err, lat, vld, held, oh); end
      dly = $urandom_range(0, 3);
      repeat (dly) begin
        @(negedge clk);
        rsp_ready = 4'($urandom_range(0, 15)) & ~oh;
        n_cmp++; if (rsp_valid !== oh || rsp_result !== held) begin n_fail++; $display("FAIL rand_hold: txn %0d vld %b res %h want %b %h", t, rsp_valid, rsp_result, oh, held); end
      end
      rsp_ready = oh;
      @(negedge clk);
      rsp_ready = '0;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_idle: txn %0d busy %b want 0", t, busy); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < NR; i++) begin op_a[i] = '0; op_b[i] = '0; end
    test_reset();
    test_single();
    test_all_four();
    test_hold();
    test_timeout();
    test_corner();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin controller that shares one iterative radix-4 Booth multiplier (32x32 signed, 64-bit result) among `NUM_REQ` requesters. It accepts one operand pair at a time and sequences the multiplier through its enable/reset/accumulate protocol. It captures the 64-bit product on the multiplier's done pulse and returns it to the owning requester over a valid/ready response channel. It sits between client datapaths and the single multiplier instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 24: maximum RUN-state cycles before the transaction is aborted.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  one-hot grant/accept, combinational.
- `req_a`, `req_b`  in  NUM_REQ*32  packed signed operands; slice i belongs to requester i.
- `rsp_valid`  out  NUM_REQ  one-hot response valid to the owning requester.
- `rsp_ready`  in  NUM_REQ  per-requester response ready.
- `rsp_result`  out  64  shared signed product.
- `rsp_err`  out  1  qualifies `rsp_valid`; 1 = timeout, and `rsp_result` = 0.
- `busy`  out  1  high in every state except IDLE.
- `mul_a`, `mul_b`  out  32  multiplier operands, held stable for the whole transaction.
- `mul_enable`, `mul_reset`  out  1  multiplier enable and (active-high) restart.
- `mul_done`  in  1  multiplier result-ready pulse.
- `mul_result`  in  64  multiplier product; valid while `mul_done` = 1.

## Operation
- FSM states: IDLE, CLR, WAIT, RUN, RESP.
- **IDLE**
  - `req_ready` is asserted only for the round-robin winner among `req_valid`. The search starts at `rr_ptr`.
  - On accept: latch the operands into `mul_a`/`mul_b`, latch the owner id, set `rr_ptr` = id+1 (mod NUM_REQ), go to CLR.
  - If no requester is valid, `req_ready` = 0.
- **CLR**: `mul_enable`=1 and `mul_reset`=1 for one cycle, then go to WAIT.
- **WAIT**: `mul_enable`=1 and `mul_reset`=0 for one cycle; this is the multiplier's reset-settle cycle. Then go to RUN and clear the cycle counter.
- **RUN**
  - `mul_enable` = !`mul_done` (combinational). This keeps the multiplier from running a 17th step.
  - On `mul_done`=1: register `mul_result` into `rsp_result`, set `rsp_err`=0, go to RESP.
  - If the counter reaches TIMEOUT without `mul_done`: `rsp_result`=0, `rsp_err`=1, go to RESP.
- **RESP**
  - `rsp_valid[id]`=1; `rsp_result` and `rsp_err` are held stable.
  - On `rsp_ready[id]`=1, go to IDLE. `rsp_ready` on other bits is ignored.
  - No new grant is issued until the following IDLE cycle.
- Arithmetic: two's complement throughout. Full signed range is supported, including 0x8000_0000 operands.
- Reset values: state=IDLE, `rr_ptr`=0, `rsp_result`=0, `rsp_err`=0. All outputs are 0, including `mul_a`, `mul_b`, `mul_enable`, `mul_reset`.
- Reset during any state aborts the transaction and drops the response. Multiplier internal state is not a concern, because every transaction starts with CLR.
- A requester may deassert `req_valid` before it is granted. There is no starvation: the worst-case wait is NUM_REQ-1 transactions.

## Timing
- Cycle 0: accept (`req_valid[i]` & `req_ready[i]`).
- Cycle 1: CLR. Cycle 2: WAIT.
- Cycles 3..18: RUN, 16 multiplier accumulations.
- Cycle 19: `mul_done`=1 and `mul_enable`=0; the result is captured at the end of this cycle.
- Cycle 20: `rsp_valid` rises. Accept-to-response latency is 20 cycles.
- Throughput: one product per 21 cycles when `rsp_ready` is held high. The cycle after the handshake is IDLE.
- `mul_a`/`mul_b` change only at accept.

## Structure
- Package `booth_arb_pkg`:
  - state enum
  - `OP_W`=32, `RES_W`=64
  - `MUL_STEPS`=16
  - default TIMEOUT
- One sub-module, `rr_arbiter`: a parameterized round-robin one-hot grant from request vector and pointer. It is combinational; the pointer register lives in the parent.
- Total 150-250 lines of RTL.

## Test plan
- Single request: requester 0, a=3, b=-5 -> `rsp_valid[0]` at cycle 20, result 0xFFFF_FFFF_FFFF_FFF1, `rsp_err`=0.
- All four requesters valid at once with distinct operands -> grants in order 0,1,2,3, each response correct, 21-cycle spacing.
- Hold `rsp_ready[2]` low for 5 cycles while requesters 0 and 3 are valid -> result is held stable, no grant issued, next grant goes to 3 then 0.
- Drive `reset`=0 in RUN cycle 10 -> all outputs are 0 the next cycle. A following request 7x6 returns 42.
- Tie `mul_done`=0 -> `rsp_valid` with `rsp_err`=1 and result 0 after TIMEOUT RUN cycles.
- a=b=0x8000_0000 -> 0x4000_0000_0000_0000. a=0x7FFF_FFFF, b=-1 -> 0xFFFF_FFFF_8000_0001.
